// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: sequencing controller for the external combinational ALU.
// It accepts one operation at a time and issues it to the ALU. Single-cycle
// ops execute in one cycle. MULTU runs as a 32-step shift-add loop on the
// ALU's ADD. SRL shifts one bit per cycle. Each completion is reported with a
// registered one-cycle done pulse.
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE. A request offered
// while busy is simply not taken, and nothing is queued. The requester must
// hold req_valid and its payload until the accepting edge.
module alu_op_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [CNT_W-1:0] shamt,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done,
  output logic             illegal,
  output logic             busy,
  output logic [WIDTH-1:0] alu_in0,
  output logic [WIDTH-1:0] alu_in1,
  output logic [5:0]       alu_signal,
  output logic             alu_binvert,
  input  logic [WIDTH-1:0] alu_out,
  output logic [2:0]       dbg_state
);

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MULTU = 6'b011001;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXEC  = 3'd1,
    S_MUL   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q;
  logic [5:0]       funct_q;
  logic [WIDTH-1:0] a_q;        // operand A, multiplicand M for MULTU
  logic [WIDTH-1:0] b_q;        // operand B, P_lo for MULTU, shift value for SRL
  logic [WIDTH-1:0] p_hi_q;     // upper product word during MULTU
  logic [CNT_W-1:0] shamt_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             illegal_q;
  logic             busy_q;
  logic             ready_q;

  logic             accept;
  state_t           first_state_d;
  logic             mul_carry;
  logic [WIDTH-1:0] p_hi_d;
  logic [WIDTH-1:0] p_lo_d;
  logic [WIDTH-1:0] shift_d;

  // Choose the first working state from the incoming operation code.
  function automatic state_t decode_first(input logic [5:0] f, input logic [CNT_W-1:0] sh);
    state_t s;
    case (f)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT: s = S_EXEC;
      F_SRL:                            s = (sh == '0) ? S_EXEC : S_SHIFT;
      F_MULTU:                          s = S_MUL;
      default:                          s = S_DONE;
    endcase
    return s;
  endfunction

  assign accept = req_valid && ready_q;

  // Decode of the request currently presented, used at the accepting edge.
  always_comb begin
    first_state_d = decode_first(funct, shamt);
  end

  // One shift-add step: add M to P_hi when the multiplier LSB is set, then
  // shift the 65-bit {carry, P_hi, P_lo} right by one.
  always_comb begin
    mul_carry = (p_hi_q[WIDTH-1] & a_q[WIDTH-1]) |
                ((p_hi_q[WIDTH-1] | a_q[WIDTH-1]) & ~alu_out[WIDTH-1]);
    if (b_q[0]) begin
      {p_hi_d, p_lo_d} = {mul_carry, alu_out, b_q[WIDTH-1:1]};
    end else begin
      {p_hi_d, p_lo_d} = {1'b0, p_hi_q, b_q[WIDTH-1:1]};
    end
    shift_d = {1'b0, b_q[WIDTH-1:1]};
  end

  // ALU operand/function drive. It is parked on ADD 0+0 unless EXEC or MUL needs it.
  always_comb begin
    alu_in0     = '0;
    alu_in1     = '0;
    alu_signal  = F_ADD;
    alu_binvert = 1'b0;
    case (state_q)
      S_EXEC: begin
        alu_in0     = a_q;
        alu_in1     = b_q;
        alu_signal  = funct_q;
        alu_binvert = (funct_q == F_SUB) || (funct_q == F_SLT);
      end
      S_MUL: begin
        alu_in0 = p_hi_q;
        alu_in1 = a_q;
      end
      default: ;
    endcase
  end

  // Control FSM with its datapath registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      funct_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      p_hi_q    <= '0;
      shamt_q   <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            funct_q <= funct;
            a_q     <= src_a;
            b_q     <= src_b;
            shamt_q <= shamt;
            p_hi_q  <= '0;
            cnt_q   <= '0;
            state_q <= first_state_d;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            if (first_state_d == S_DONE) begin
              // Unsupported code: report it immediately, leave hi/lo alone.
              result_q  <= '0;
              illegal_q <= 1'b1;
              done_q    <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          // A zero-length SRL passes B through untouched.
          result_q <= (funct_q == F_SRL) ? b_q : alu_out;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_MUL: begin
          p_hi_q <= p_hi_d;
          b_q    <= p_lo_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            hi_q     <= p_hi_d;
            lo_q     <= p_lo_d;
            result_q <= p_lo_d;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_SHIFT: begin
          b_q   <= shift_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == shamt_q - 1'b1) begin
            result_q <= shift_d;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign illegal   = illegal_q;
  assign result    = result_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: external ALU model, operation-level reference
// model, per-cycle compare and directed operations with literal results.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MULTU = 6'b011001;

  logic        clk, reset, req_valid, req_ready;
  logic [5:0]  funct;
  logic [31:0] src_a, src_b;
  logic [4:0]  shamt;
  logic [31:0] result, hi, lo;
  logic        done, illegal, busy;
  logic [31:0] alu_in0, alu_in1, alu_out;
  logic [5:0]  alu_signal;
  logic        alu_binvert;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  alu_op_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .funct(funct), .src_a(src_a), .src_b(src_b), .shamt(shamt),
    .result(result), .hi(hi), .lo(lo), .done(done), .illegal(illegal), .busy(busy),
    .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_signal(alu_signal),
    .alu_binvert(alu_binvert), .alu_out(alu_out), .dbg_state(dbg_state)
  );

  // ---------------- clock/reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- external combinational ALU ----------------
  always_comb begin
    case (alu_signal)
      F_AND:        alu_out = alu_in0 & alu_in1;
      F_OR:         alu_out = alu_in0 | alu_in1;
      F_ADD, F_SUB: alu_out = alu_in0 + (alu_binvert ? ~alu_in1 : alu_in1) + {31'd0, alu_binvert};
      F_SLT:        alu_out = {31'd0, $signed(alu_in0) < $signed(alu_in1)};
      default:      alu_out = 32'd0;
    endcase
  end

  // ---------------- operation-level reference model ----------------
  // m_cnt = edges still to go before the done cycle; m_kind: 0 none, 1 exec, 2 mul.
  logic        m_active;
  int          m_cnt;
  int          m_kind;
  logic [5:0]  m_f;
  logic [31:0] m_a, m_b;
  logic        m_ill, p_mul;
  logic [31:0] p_res;
  logic [63:0] prod;
  logic [31:0] m_res, m_hi, m_lo;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 1'b0; m_cnt = 0; m_kind = 0; m_ill = 1'b0; p_mul = 1'b0;
      m_res = '0; m_hi = '0; m_lo = '0; m_f = '0; m_a = '0; m_b = '0;
      p_res = '0; prod = '0;
    end else begin
      if (m_active) begin
        if (m_cnt == 0) m_active = 1'b0;
        else m_cnt = m_cnt - 1;
      end else if (req_valid) begin
        m_active = 1'b1; m_f = funct; m_a = src_a; m_b = src_b;
        m_ill = 1'b0; p_mul = 1'b0; m_kind = 1; m_cnt = 1;
        case (funct)
          F_AND: p_res = src_a & src_b;
          F_OR:  p_res = src_a | src_b;
          F_ADD: p_res = src_a + src_b;
          F_SUB: p_res = src_a - src_b;
          F_SLT: p_res = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
          F_SRL: begin
            p_res = src_b >> shamt;
            if (shamt != 0) begin m_cnt = int'(shamt); m_kind = 0; end
          end
          F_MULTU: begin
            prod = {32'd0, src_a} * {32'd0, src_b};
            p_res = prod[31:0]; p_mul = 1'b1; m_cnt = 32; m_kind = 2;
          end
          default: begin p_res = '0; m_ill = 1'b1; m_cnt = 0; m_kind = 0; end
        endcase
      end
      if (m_active && m_cnt == 0) begin
        m_res = p_res;
        if (p_mul) begin m_hi = prod[63:32]; m_lo = prod[31:0]; end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the model.
  task automatic compare_cycle();
    logic exp_done;
    logic in_exec, in_mul;
    exp_done = m_active && (m_cnt == 0);
    in_exec  = m_active && (m_cnt > 0) && (m_kind == 1);
    in_mul   = m_active && (m_cnt > 0) && (m_kind == 2);
    chk("done", 64'(done), 64'(exp_done));
    chk("illegal", 64'(illegal), 64'(exp_done && m_ill));
    chk("busy", 64'(busy), 64'(m_active));
    chk("req_ready", 64'(req_ready), 64'(!m_active));
    chk("result", 64'(result), 64'(m_res));
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
    if (in_exec) begin
      chk("alu_in0 exec", 64'(alu_in0), 64'(m_a));
      chk("alu_in1 exec", 64'(alu_in1), 64'(m_b));
      chk("alu_signal exec", 64'(alu_signal), 64'(m_f));
      chk("alu_binvert exec", 64'(alu_binvert), 64'((m_f == F_SUB) || (m_f == F_SLT)));
    end else if (in_mul) begin
      chk("alu_in1 mul", 64'(alu_in1), 64'(m_a));
      chk("alu_signal mul", 64'(alu_signal), 64'(F_ADD));
      chk("alu_binvert mul", 64'(alu_binvert), 64'd0);
    end else begin
      chk("alu_in0 idle", 64'(alu_in0), 64'd0);
      chk("alu_in1 idle", 64'(alu_in1), 64'd0);
      chk("alu_signal idle", 64'(alu_signal), 64'(F_ADD));
      chk("alu_binvert idle", 64'(alu_binvert), 64'd0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
  endtask

  // ---------------- driver tasks ----------------
  // Offer one request, wait for acceptance and done, check literal result and latency
  // (latency counts the acceptance cycle as cycle 1).
  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh,
                        input logic [31:0] exp_res, input int exp_lat, input logic exp_ill);
    int cnt;
    funct = f; src_a = a; src_b = b; shamt = sh; req_valid = 1'b1;
    cnt = 0;
    while (!req_ready && cnt < 100) begin tick(); cnt++; end
    chk({name, " accept timeout"}, 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    cnt = 0;
    while (!done && cnt < 100) begin tick(); cnt++; end
    chk({name, " latency"}, 64'(cnt + 1), 64'(exp_lat));
    chk({name, " result"}, 64'(result), 64'(exp_res));
    chk({name, " illegal"}, 64'(illegal), 64'(exp_ill));
    tick();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int cnt;
    reset = 1'b1; req_valid = 1'b0; funct = '0; src_a = '0; src_b = '0; shamt = '0;
    tick();
    tick();
    chk("reset result", 64'(result), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset req_ready", 64'(req_ready), 64'd1);
    reset = 1'b0;
    tick();

    run_op("ADD 5+7", F_ADD, 32'd5, 32'd7, 5'd0, 32'h0000000C, 2, 1'b0);
    run_op("SUB 3-5", F_SUB, 32'd3, 32'd5, 5'd0, 32'hFFFFFFFE, 2, 1'b0);
    run_op("SLT -1<1", F_SLT, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd1, 2, 1'b0);
    run_op("SLT 1<-1", F_SLT, 32'd1, 32'hFFFFFFFF, 5'd0, 32'd0, 2, 1'b0);
    run_op("AND", F_AND, 32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h0000F000, 2, 1'b0);
    run_op("OR", F_OR, 32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h0000FFF0, 2, 1'b0);
    run_op("MULTU max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h00000001, 33, 1'b0);
    chk("MULTU max hi", 64'(hi), 64'hFFFFFFFE);
    chk("MULTU max lo", 64'(lo), 64'h00000001);
    run_op("MULTU 2^16", F_MULTU, 32'h00010000, 32'h00010000, 5'd0, 32'd0, 33, 1'b0);
    chk("MULTU 2^16 hi", 64'(hi), 64'd1);
    chk("MULTU 2^16 lo", 64'(lo), 64'd0);
    run_op("SRL 31", F_SRL, 32'h80000000, 32'h80000000, 5'd31, 32'd1, 32, 1'b0);
    run_op("SRL 0", F_SRL, 32'd0, 32'h00001234, 5'd0, 32'h00001234, 2, 1'b0);
    run_op("SRL 4", F_SRL, 32'd0, 32'hF0000000, 5'd4, 32'h0F000000, 5, 1'b0);
    run_op("illegal", 6'b111111, 32'd9, 32'd9, 5'd0, 32'd0, 1, 1'b1);
    chk("illegal keeps hi", 64'(hi), 64'd1);
    chk("illegal keeps lo", 64'(lo), 64'd0);

    // req_valid held through a MULTU: the next request waits for req_ready.
    funct = F_MULTU; src_a = 32'd12345; src_b = 32'd6789; shamt = '0; req_valid = 1'b1;
    tick();
    funct = F_ADD; src_a = 32'd1; src_b = 32'd2;
    cnt = 0;
    while (!done && cnt < 100) begin tick(); cnt++; end
    chk("held MULTU latency", 64'(cnt + 1), 64'd33);
    chk("held MULTU lo", 64'(lo), 64'h04FED79D);
    chk("held MULTU hi", 64'(hi), 64'd0);
    tick();
    chk("held ready back", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    cnt = 0;
    while (!done && cnt < 100) begin tick(); cnt++; end
    chk("held ADD latency", 64'(cnt + 1), 64'd2);
    chk("held ADD result", 64'(result), 64'd3);
    tick();

    // Reset during MUL iteration 10 aborts the operation.
    funct = F_MULTU; src_a = 32'd7; src_b = 32'd9; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (10) tick();
    chk("mid-MUL busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("abort result", 64'(result), 64'd0);
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort lo", 64'(lo), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    tick();
    reset = 1'b0;
    cnt = 0;
    repeat (30) begin tick(); if (done) cnt++; end
    chk("no done after abort", 64'(cnt), 64'd0);
    run_op("ADD 1+1", F_ADD, 32'd1, 32'd1, 5'd0, 32'd2, 2, 1'b0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Sequencing controller for the team's combinational 32-bit ALU, which is instantiated outside this block and driven through the alu_* ports.
- Accepts one MIPS-funct-coded operation at a time over a valid/ready handshake.
- Single-cycle ops are issued to the ALU directly. MULTU is run as a 32-iteration shift-add loop using the ALU's ADD. SRL is run as an iterative 1-bit-per-cycle shifter.
- Results are registered with a one-cycle done pulse; HI/LO are kept for MULTU.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.
- CNT_W, 5, iteration counter width, equal to log2(WIDTH).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request; high only in IDLE.
- funct  input  6  operation: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, SRL 000010, MULTU 011001.
- src_a  input  32  operand A (multiplicand for MULTU).
- src_b  input  32  operand B (multiplier for MULTU; shifted value for SRL).
- shamt  input  5  SRL shift amount.
- result  output  32  registered result; LO for MULTU.
- hi  output  32  MULTU upper word.
- lo  output  32  MULTU lower word.
- done  output  1  one-cycle pulse: result, hi and lo are valid.
- illegal  output  1  high with done when funct is unsupported.
- busy  output  1  high whenever state is not IDLE.
- alu_in0  output  32  ALU operand 0.
- alu_in1  output  32  ALU operand 1.
- alu_signal  output  6  ALU function code.
- alu_binvert  output  1  ALU B-invert / carry-in.
- alu_out  input  32  ALU combinational result.

Behaviour:
- Reset, asynchronous: state=IDLE; result, hi, lo, done, illegal, busy, counter and operand registers are all 0.
- Reset asserted mid-operation aborts the operation. No done pulse follows. hi/lo return to 0.
- Handshake: accept at a rising edge E0 where req_valid and req_ready are both high. At E0, latch funct, src_a, src_b, shamt. req_valid while busy is ignored, with no queuing.
- State IDLE: go to EXEC, MUL, SHIFT or DONE according to the latched funct.
- State EXEC (AND, OR, ADD, SUB, SLT; also SRL with shamt=0): one cycle.
  - ALU driven with in0=a, in1=b, signal=funct, binvert=1 for SUB/SLT, else 0.
  - At E1: result<=alu_out (for shamt=0 SRL, result<=b); go to DONE.
- State MUL (MULTU): 32 cycles, counter 0..31.
  - Initial values at E0: P_hi=0, P_lo=b, M=a.
  - Each cycle: ALU driven with in0=P_hi, in1=M, signal=ADD, binvert=0.
  - If P_lo[0]=1: carry = (P_hi[31]&M[31]) | ((P_hi[31]|M[31]) & ~alu_out[31]); {P_hi,P_lo} <= {carry, alu_out, P_lo[31:1]}.
  - Else: {P_hi,P_lo} <= {1'b0, P_hi, P_lo[31:1]}.
  - At E32: hi<=P_hi_next, lo<=P_lo_next, result<=P_lo_next; go to DONE.
- State SHIFT (SRL, shamt=n>0): n cycles, value <= value>>1 with zero fill. At E_n: result<=value; go to DONE.
- State DONE: one cycle. done=1, busy=1, req_ready=0. Next state IDLE.
- Done timing:
  - Single-cycle ops: done high in the cycle after E1, i.e. 2 cycles after acceptance.
  - MULTU: done high after E32, i.e. 33 cycles after acceptance.
  - SRL: done high after E_n.
- Illegal funct: IDLE goes straight to DONE. result=0, illegal=1 for that cycle. hi/lo unchanged.
- hi/lo change only on MULTU completion or reset. result holds until the next completion.
- ALU idle drive (IDLE, SHIFT, DONE): alu_in0=0, alu_in1=0, alu_signal=ADD, alu_binvert=0.
- No arithmetic overflow flag. ADD/SUB wrap modulo 2^32. SLT is signed, as computed by the ALU.

Test Plan:
- ADD a=5, b=7 -> done exactly 2 cycles after acceptance, result=0x0000000C, illegal=0; SUB a=3, b=5 -> result=0xFFFFFFFE.
- SLT a=0xFFFFFFFF, b=1 -> result=1; SLT a=1, b=0xFFFFFFFF -> result=0; during EXEC alu_binvert=1 and alu_signal=101010.
- MULTU a=b=0xFFFFFFFF -> 33 cycles to done, hi=0xFFFFFFFE, lo=result=0x00000001; MULTU a=0x00010000, b=0x00010000 -> hi=1, lo=0.
- SRL b=0x80000000, shamt=31 -> result=1 with done after 31 shift cycles; shamt=0, b=0x1234 -> result=0x1234 at 2-cycle latency.
- funct=111111 -> one-cycle done with illegal=1, result=0; req_valid held during MULTU -> not accepted until req_ready returns.
- reset pulsed at MUL iteration 10 -> outputs 0, no done; a following ADD 1+1 completes normally with result=2.
